// File: rtl/cotm32_pkg.sv
// -----------------------------------------------------------------------------
// cotm32_pkg
// Shared types and constants for the cotm32 core slice.
//   XLEN        : machine word width
//   BYTE_WIDTH  : bits per byte lane
//   LANES       : byte lanes per word
//   OFF_W       : width of the byte offset inside a word
//   dmem_state_t: data-memory responder FSM states
// -----------------------------------------------------------------------------
package cotm32_pkg;

  localparam int XLEN       = 32;
  localparam int BYTE_WIDTH = 8;
  localparam int LANES      = XLEN / BYTE_WIDTH;
  localparam int OFF_W      = $clog2(LANES);

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane steering for the data-memory responder.
// Moves low-justified store data / byte enables up to the address byte offset
// and brings the addressed bytes of a RAM word back down to bit 0.
//   off      in  byte offset inside the word (addr[1:0])
//   be       in  low-justified byte enable
//   wdata    in  low-lane-justified store data
//   rword    in  raw RAM word
//   sbe      out byte enable shifted to the offset, in-word lanes only
//   wdata_sh out store data shifted to the offset
//   rdata    out load data right-justified and masked to the enabled lanes
//   mis      out some enabled byte was shifted past the top lane
// -----------------------------------------------------------------------------
module dmem_lane_align
  import cotm32_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN
) (
  input  logic [OFF_W-1:0]      off,
  input  logic [LANES-1:0]      be,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rword,
  output logic [LANES-1:0]      sbe,
  output logic [DATA_WIDTH-1:0] wdata_sh,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mis
);

  // Shift at double width so lanes pushed past the top are kept for mis.
  logic [2*LANES-1:0]    sbe_wide;
  logic [DATA_WIDTH-1:0] rword_sh;
  logic [DATA_WIDTH-1:0] be_mask;

  always_comb begin
    sbe_wide = {{LANES{1'b0}}, be} << off;
    sbe      = sbe_wide[LANES-1:0];
    mis      = |sbe_wide[2*LANES-1:LANES];
    wdata_sh = wdata << (BYTE_WIDTH * off);
    // Logical right shift zero-fills from the top.
    rword_sh = rword >> (BYTE_WIDTH * off);
    for (int k = 0; k < LANES; k++) begin
      be_mask[k*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{be[k]}};
    end
    rdata = rword_sh & be_mask;
  end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory slave for the load-store unit: single-ported word RAM behind a
// req/ready request channel, configurable wait states and a one-cycle rvalid
// response carrying right-justified load data and an error flag.
//
// Parameters: DATA_WIDTH (=4*BYTE_WIDTH), ADDR_WIDTH, DEPTH_WORDS,
//             WAIT_STATES (0..15).
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_req / o_ready     request handshake; o_ready is high only in IDLE
//   i_we                1 = store, 0 = load
//   i_addr              byte address; word index = i_addr[ADDR_WIDTH-1:2]
//   i_be                low-justified byte enable
//   i_wdata             low-lane-justified store data
//   o_rvalid            one-cycle response pulse
//   o_rdata, o_err      registered response, held until the next response
//
// Build option: DMEM_MISALIGN_ERR_EN -- when defined, an access whose enabled
// bytes cross the word boundary is flagged as an error and writes nothing;
// otherwise out-of-word lanes are silently dropped.
// -----------------------------------------------------------------------------
module dmem_responder
  import cotm32_pkg::*;
#(
  parameter int DATA_WIDTH  = XLEN,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  output logic                  o_ready,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [LANES-1:0]      i_be,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_rvalid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_err
);

  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  dmem_state_t state, state_d;
  logic [3:0]  cnt, cnt_d;

  // Request captured at accept.
  logic                  q_we;
  logic [ADDR_WIDTH-1:0] q_addr;
  logic [LANES-1:0]      q_be;
  logic [DATA_WIDTH-1:0] q_wdata;

  logic accept;
  logic access;

  // Request seen by the datapath: live inputs on a zero-wait accept edge,
  // the captured copy when the access follows WAIT.
  logic                  cur_we;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LANES-1:0]      cur_be;
  logic [DATA_WIDTH-1:0] cur_wdata;

  logic [IDX_W-1:0]      mem_idx;
  logic                  oor;
  logic                  blk;
  logic [DATA_WIDTH-1:0] rword;
  logic [LANES-1:0]      sbe;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] rdata_al;
  logic                  mis;
  logic [LANES-1:0]      wr_lane;
  logic [DATA_WIDTH-1:0] rdata_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    unique case (state)
      DMEM_IDLE: begin
        if (i_req) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = DMEM_RESP;
          end else begin
            state_d = DMEM_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      DMEM_WAIT: begin
        if (cnt == 4'd0) state_d = DMEM_RESP;
        else             cnt_d   = cnt - 4'd1;
      end
      DMEM_RESP: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  // The RAM access happens on the edge that enters RESP.
  assign access   = (state_d == DMEM_RESP) && (state != DMEM_RESP);
  assign o_ready  = (state == DMEM_IDLE);
  assign o_rvalid = (state == DMEM_RESP);

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    if (state == DMEM_IDLE) begin
      cur_we    = i_we;
      cur_addr  = i_addr;
      cur_be    = i_be;
      cur_wdata = i_wdata;
    end else begin
      cur_we    = q_we;
      cur_addr  = q_addr;
      cur_be    = q_be;
      cur_wdata = q_wdata;
    end
  end

  assign mem_idx = cur_addr[IDX_W+1:2];
  assign oor     = (cur_addr >> 2) >= ADDR_WIDTH'(DEPTH_WORDS);
  assign rword   = mem[mem_idx];

  dmem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .off      (cur_addr[OFF_W-1:0]),
    .be       (cur_be),
    .wdata    (cur_wdata),
    .rword    (rword),
    .sbe      (sbe),
    .wdata_sh (wdata_sh),
    .rdata    (rdata_al),
    .mis      (mis)
  );

`ifdef DMEM_MISALIGN_ERR_EN
  assign blk = oor | mis;
`else
  assign blk = oor;
`endif

  // i_rst_n gates the write so a request presented while reset is held can
  // never reach the RAM, which has no reset of its own.
  assign wr_lane = {LANES{access & cur_we & ~blk & i_rst_n}} & sbe;
  assign rdata_d = (cur_we || blk) ? '0 : rdata_al;

  // ---------------------------------------------------------------------------
  // State, capture and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!i_rst_n) begin
      state   <= DMEM_IDLE;
      cnt     <= 4'd0;
      q_we    <= 1'b0;
      q_addr  <= '0;
      q_be    <= '0;
      q_wdata <= '0;
      o_rdata <= '0;
      o_err   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        q_we    <= i_we;
        q_addr  <= i_addr;
        q_be    <= i_be;
        q_wdata <= i_wdata;
      end
      if (access) begin
        o_rdata <= rdata_d;
        o_err   <= blk;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Word RAM with per-lane write enables
  // ---------------------------------------------------------------------------
  // NOTE: the RAM array is deliberately left out of reset so it maps onto a
  // real memory macro; its contents are undefined until written.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (wr_lane[k]) begin
        mem[mem_idx][k*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_sh[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder. Three instances share clock and reset:
// u_dut (WAIT_STATES=1) for the functional tests, u_dut0 (WAIT_STATES=0) for
// back-to-back handshake and u_dut3 (WAIT_STATES=3) for extended latency.
// Latency is counted in rising edges from the accept edge to the first edge
// after which o_rvalid is seen high.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // u_dut signals
  logic        req, we, ready, rvalid, err;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  // u_dut0 signals
  logic        req0, we0, ready0, rvalid0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  be0;
  // u_dut3 signals
  logic        req3, we3, ready3, rvalid3, err3;
  logic [31:0] addr3, wdata3, rdata3;
  logic [3:0]  be3;

  dmem_responder #(.WAIT_STATES(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .o_ready(ready), .i_we(we),
    .i_addr(addr), .i_be(be), .i_wdata(wdata), .o_rvalid(rvalid),
    .o_rdata(rdata), .o_err(err)
  );

  dmem_responder #(.WAIT_STATES(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req0), .o_ready(ready0), .i_we(we0),
    .i_addr(addr0), .i_be(be0), .i_wdata(wdata0), .o_rvalid(rvalid0),
    .o_rdata(rdata0), .o_err(err0)
  );

  dmem_responder #(.WAIT_STATES(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req3), .o_ready(ready3), .i_we(we3),
    .i_addr(addr3), .i_be(be3), .i_wdata(wdata3), .o_rvalid(rvalid3),
    .o_rdata(rdata3), .o_err(err3)
  );

  // One transaction on u_dut. After the accept edge the request inputs are
  // scrambled to show they are ignored while o_ready is low. lat is -1 if no
  // response arrives within the budget.
  task automatic xact(input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, output logic [31:0] rd,
                      output logic er, output int lat);
    int n;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req = 1'b0; we = ~w; addr = $urandom; be = 4'hF; wdata = $urandom;
    lat = 0;
    while (!rvalid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rvalid) lat = -1;
    rd = rdata;
    er = err;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else pass_cnt++;
    total_cnt++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", rvalid); else pass_cnt++;
    total_cnt++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 00000000", rdata); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else pass_cnt++;
    total_cnt++; if (ready0 !== 1'b1 || ready3 !== 1'b1) $display("FAIL reset_ready_ws: got %b%b want 11", ready0, ready3); else pass_cnt++;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, er, lat);
    total_cnt++; if (lat !== 1) $display("FAIL word_store_lat: got %0d want 1", lat); else pass_cnt++;
    total_cnt++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL word_store_resp: got %h/%b want 00000000/0", rd, er); else pass_cnt++;
    xact(1'b0, 32'h10, 4'hF, 32'h0, rd, er, lat);
    total_cnt++; if (lat !== 1) $display("FAIL word_load_lat: got %0d want 1", lat); else pass_cnt++;
    total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL word_load_data: got %h want deadbeef", rd); else pass_cnt++;
    total_cnt++; if (er !== 1'b0) $display("FAIL word_load_err: got %b want 0", er); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (rvalid !== 1'b0) $display("FAIL word_rvalid_pulse: got %b want 0", rvalid); else pass_cnt++;
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, 32'h10, 4'hF, 32'h11223344, rd, er, lat);
    // Upper bytes of the store data are junk and must not reach the RAM.
    xact(1'b1, 32'h13, 4'b0001, 32'hCCCCCCAB, rd, er, lat);
    xact(1'b0, 32'h10, 4'hF, 32'h0, rd, er, lat);
    total_cnt++; if (rd !== 32'hAB223344) $display("FAIL byte_store_word: got %h want ab223344", rd); else pass_cnt++;
    xact(1'b0, 32'h13, 4'b0001, 32'h0, rd, er, lat);
    total_cnt++; if (rd !== 32'h000000AB) $display("FAIL byte_load: got %h want 000000ab", rd); else pass_cnt++;
    xact(1'b0, 32'h12, 4'b0011, 32'h0, rd, er, lat);
    total_cnt++; if (rd !== 32'h0000AB22) $display("FAIL half_load: got %h want 0000ab22", rd); else pass_cnt++;
    xact(1'b0, 32'h11, 4'b0001, 32'h0, rd, er, lat);
    total_cnt++; if (rd !== 32'h00000033) $display("FAIL byte_load_off1: got %h want 00000033", rd); else pass_cnt++;
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] exp_word, exp_ld;
    logic        exp_err;
`ifdef DMEM_MISALIGN_ERR_EN
    exp_word = 32'h11223344; exp_ld = 32'h00000000; exp_err = 1'b1;
`else
    exp_word = 32'h66223344; exp_ld = 32'h00000066; exp_err = 1'b0;
`endif
    xact(1'b1, 32'h14, 4'hF, 32'h11223344, rd, er, lat);
    xact(1'b1, 32'h17, 4'b0011, 32'h00005566, rd, er, lat);
    total_cnt++; if (er !== exp_err) $display("FAIL mis_store_err: got %b want %b", er, exp_err); else pass_cnt++;
    xact(1'b0, 32'h14, 4'hF, 32'h0, rd, er, lat);
    total_cnt++; if (rd !== exp_word) $display("FAIL mis_store_word: got %h want %h", rd, exp_word); else pass_cnt++;
    xact(1'b0, 32'h17, 4'b0011, 32'h0, rd, er, lat);
    total_cnt++; if (rd !== exp_ld || er !== exp_err) $display("FAIL mis_load: got %h/%b want %h/%b", rd, er, exp_ld, exp_err); else pass_cnt++;
  endtask

  task automatic test_be_zero();
    logic [31:0] rd; logic er; int lat;
    xact(1'b0, 32'h10, 4'b0000, 32'h0, rd, er, lat);
    total_cnt++; if (rd !== 32'h0 || er !== 1'b0 || lat !== 1) $display("FAIL be0_load: got %h/%b/%0d want 00000000/0/1", rd, er, lat); else pass_cnt++;
    xact(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, rd, er, lat);
    xact(1'b0, 32'h10, 4'hF, 32'h0, rd, er, lat);
    total_cnt++; if (rd !== 32'hAB223344) $display("FAIL be0_store_word: got %h want ab223344", rd); else pass_cnt++;
  endtask

  task automatic test_oor();
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, 32'h0, 4'hF, 32'h01020304, rd, er, lat);
    xact(1'b1, 32'hFFC, 4'hF, 32'h0BADF00D, rd, er, lat);
    xact(1'b0, 32'h1000, 4'hF, 32'h0, rd, er, lat);
    total_cnt++; if (rd !== 32'h0 || er !== 1'b1 || lat !== 1) $display("FAIL oor_load: got %h/%b/%0d want 00000000/1/1", rd, er, lat); else pass_cnt++;
    // 0x1000 aliases word 0 in the low index bits; word 0 must survive.
    xact(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, rd, er, lat);
    total_cnt++; if (er !== 1'b1) $display("FAIL oor_store_err: got %b want 1", er); else pass_cnt++;
    xact(1'b0, 32'h0, 4'hF, 32'h0, rd, er, lat);
    total_cnt++; if (rd !== 32'h01020304 || er !== 1'b0) $display("FAIL oor_store_alias: got %h/%b want 01020304/0", rd, er); else pass_cnt++;
    xact(1'b0, 32'hFFC, 4'hF, 32'h0, rd, er, lat);
    total_cnt++; if (rd !== 32'h0BADF00D || er !== 1'b0) $display("FAIL last_word: got %h/%b want 0badf00d/0", rd, er); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic exp_rv;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; be0 = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      wdata0 = 32'h100 + 32'(k);
      @(posedge clk); #1;
      exp_rv = (k % 2) == 1;
      total_cnt++; if (rvalid0 !== exp_rv) $display("FAIL b2b_rvalid_%0d: got %b want %b", k, rvalid0, exp_rv); else pass_cnt++;
      total_cnt++; if (ready0 !== !exp_rv) $display("FAIL b2b_ready_%0d: got %b want %b", k, ready0, !exp_rv); else pass_cnt++;
      @(negedge clk);
    end
    we0 = 1'b0; wdata0 = 32'h0;
    @(posedge clk); #1;
    req0 = 1'b0;
    // Stores accepted at edges 1, 3, 5; the last one carried 0x105.
    total_cnt++; if (rvalid0 !== 1'b1 || rdata0 !== 32'h105 || err0 !== 1'b0) $display("FAIL b2b_load: got %b/%h/%b want 1/00000105/0", rvalid0, rdata0, err0); else pass_cnt++;
  endtask

  task automatic test_wait3();
    int lat;
    @(negedge clk);
    req3 = 1'b1; we3 = 1'b1; addr3 = 32'h30; be3 = 4'hF; wdata3 = 32'hCAFEF00D;
    @(posedge clk); #1;
    req3 = 1'b0; wdata3 = 32'h0;
    lat = 0;
    while (!rvalid3 && lat < 20) begin @(posedge clk); #1; lat++; end
    total_cnt++; if (lat !== 3) $display("FAIL ws3_store_lat: got %0d want 3", lat); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (rvalid3 !== 1'b0) $display("FAIL ws3_pulse: got %b want 0", rvalid3); else pass_cnt++;
    @(negedge clk);
    req3 = 1'b1; we3 = 1'b0;
    @(posedge clk); #1;
    req3 = 1'b0;
    lat = 0;
    while (!rvalid3 && lat < 20) begin @(posedge clk); #1; lat++; end
    total_cnt++; if (lat !== 3 || rdata3 !== 32'hCAFEF00D) $display("FAIL ws3_load: got %0d/%h want 3/cafef00d", lat, rdata3); else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd; logic er; int lat;
    xact(1'b1, 32'h40, 4'hF, 32'h12345678, rd, er, lat);
    xact(1'b0, 32'h40, 4'hF, 32'h0, rd, er, lat);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h40; be = 4'hF; wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (rdata !== 32'h0 || rvalid !== 1'b0 || err !== 1'b0) $display("FAIL midop_outputs: got %h/%b/%b want 00000000/0/0", rdata, rvalid, err); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (ready !== 1'b1) $display("FAIL midop_ready: got %b want 1", ready); else pass_cnt++;
    xact(1'b0, 32'h40, 4'hF, 32'h0, rd, er, lat);
    total_cnt++; if (rd !== 32'h12345678) $display("FAIL midop_word: got %h want 12345678", rd); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    req  = 1'b0; we  = 1'b0; addr  = '0; be  = '0; wdata  = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; be0 = '0; wdata0 = '0;
    req3 = 1'b0; we3 = 1'b0; addr3 = '0; be3 = '0; wdata3 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_word();
    test_byte_lanes();
    test_misaligned();
    test_be_zero();
    test_oor();
    test_back_to_back();
    test_wait3();
    test_reset_midop();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
